// File: rtl/dm_sram_ctrl_if.sv
// Pipeline-side data-memory request/response bundle.
// The pipeline (master) drives requests, and the SRAM controller (slave) answers them.
interface dm_sram_ctrl_if;
  logic        re;
  logic        we;
  logic [31:0] addr;
  logic [3:0]  be_n;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        stall;

  modport master (
    output re, we, addr, be_n, wdata,
    input  rdata, stall
  );

  modport slave (
    input  re, we, addr, be_n, wdata,
    output rdata, stall
  );
endinterface

// File: rtl/dm_sram_ctrl.sv
// Data-memory responder that drives an async 32-bit SRAM.
// Accesses are multi-cycle, and the pipeline is stalled while one is in flight.
module dm_sram_ctrl #(
  parameter int RD_WAIT = 2,
  parameter int WR_WAIT = 2,
  parameter int SRAM_AW = 20
) (
  input  logic               clk,
  input  logic               rst_n,
  dm_sram_ctrl_if.slave      dm,
  output logic [SRAM_AW-1:0] sram_addr_o,
  output logic [31:0]        sram_wdata_o,
  output logic               sram_data_oe_o,
  input  logic [31:0]        sram_rdata_i,
  output logic               sram_ce_n_o,
  output logic               sram_oe_n_o,
  output logic               sram_we_n_o,
  output logic [3:0]         sram_be_n_o
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_READ  = 3'd1;
  localparam logic [2:0] S_WRITE = 3'd2;
  localparam logic [2:0] S_WHOLD = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;

  localparam logic [3:0] RD_LAST = 4'(RD_WAIT - 1);
  localparam logic [3:0] WR_LAST = 4'(WR_WAIT - 1);

  logic [2:0]         state_q, state_d;
  logic [3:0]         cnt_q, cnt_d;
  logic [SRAM_AW-1:0] addr_q, addr_d;
  logic [3:0]         be_q, be_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;

  logic unused_addr;
  assign unused_addr = ^{dm.addr[31:SRAM_AW+2], dm.addr[1:0]};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    be_d    = be_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    unique case (state_q)
      S_IDLE: begin
        if (dm.we) begin
          addr_d  = dm.addr[SRAM_AW+1:2];
          be_d    = dm.be_n;
          wdata_d = dm.wdata;
          cnt_d   = '0;
          state_d = S_WRITE;
        end else if (dm.re) begin
          addr_d  = dm.addr[SRAM_AW+1:2];
          cnt_d   = '0;
          state_d = S_READ;
        end
      end
      S_READ: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == RD_LAST) begin
          rdata_d = sram_rdata_i;
          state_d = S_DONE;
        end
      end
      S_WRITE: begin
        cnt_d = cnt_q + 4'd1;
        if (cnt_q == WR_LAST) state_d = S_WHOLD;
      end
      S_WHOLD: state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      be_q    <= 4'hF;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      be_q    <= be_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  // Strobes come from registered state only, so they cannot glitch.
  always_comb begin
    sram_ce_n_o    = 1'b1;
    sram_oe_n_o    = 1'b1;
    sram_we_n_o    = 1'b1;
    sram_be_n_o    = 4'hF;
    sram_data_oe_o = 1'b0;
    unique case (state_q)
      S_READ: begin
        sram_ce_n_o = 1'b0;
        sram_oe_n_o = 1'b0;
        sram_be_n_o = 4'h0;
      end
      S_WRITE: begin
        sram_ce_n_o    = 1'b0;
        sram_we_n_o    = 1'b0;
        sram_be_n_o    = be_q;
        sram_data_oe_o = 1'b1;
      end
      S_WHOLD: begin
        sram_ce_n_o    = 1'b0;
        sram_be_n_o    = be_q;
        sram_data_oe_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_comb begin
    dm.stall = 1'b0;
    unique case (state_q)
      S_IDLE:                   dm.stall = dm.re | dm.we;
      S_READ, S_WRITE, S_WHOLD: dm.stall = 1'b1;
      default:                  dm.stall = 1'b0;
    endcase
  end

  assign dm.rdata     = rdata_q;
  assign sram_addr_o  = addr_q;
  assign sram_wdata_o = wdata_q;

endmodule

// File: tb/tb_dm_sram_ctrl.sv
// Randomized bench for dm_sram_ctrl against an async SRAM model
// and a transaction-level memory reference.
module tb_dm_sram_ctrl;
  localparam int RD_WAIT = 2;
  localparam int WR_WAIT = 2;
  localparam int SRAM_AW = 20;

  logic               clk = 1'b0;
  logic               rst_n;
  logic [SRAM_AW-1:0] sram_addr;
  logic [31:0]        sram_wdata;
  logic               sram_data_oe;
  logic [31:0]        sram_rdata;
  logic               sram_ce_n;
  logic               sram_oe_n;
  logic               sram_we_n;
  logic [3:0]         sram_be_n;

  dm_sram_ctrl_if dmif ();

  dm_sram_ctrl #(
    .RD_WAIT (RD_WAIT),
    .WR_WAIT (WR_WAIT),
    .SRAM_AW (SRAM_AW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .dm             (dmif),
    .sram_addr_o    (sram_addr),
    .sram_wdata_o   (sram_wdata),
    .sram_data_oe_o (sram_data_oe),
    .sram_rdata_i   (sram_rdata),
    .sram_ce_n_o    (sram_ce_n),
    .sram_oe_n_o    (sram_oe_n),
    .sram_we_n_o    (sram_we_n),
    .sram_be_n_o    (sram_be_n)
  );

  always #5 clk = ~clk;

  logic [31:0] smem [256];
  logic [31:0] ref_mem [256];
  logic [31:0] last_rd;
  int n_tests = 0;
  int n_fail  = 0;

  assign sram_rdata = (!sram_ce_n && !sram_oe_n) ?
                      smem[sram_addr[7:0]] : 32'hDEAD_BEEF;

  always @(posedge clk) begin
    if (!sram_ce_n && !sram_we_n)
      for (int b = 0; b < 4; b++)
        if (!sram_be_n[b])
          smem[sram_addr[7:0]][8*b +: 8] <= sram_wdata[8*b +: 8];
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic access(input bit re, input bit we, input logic [31:0] a,
                        input logic [3:0] be, input logic [31:0] wd);
    int  st = 0, oe = 0, wl = 0, hold = 0;
    bit  done = 0, addr_bad = 0, be_bad = 0;
    logic [31:0] w;
    dmif.re = re; dmif.we = we; dmif.addr = a;
    dmif.be_n = be; dmif.wdata = wd;
    #1;
    for (int i = 0; i < 64; i++) begin
      if (!dmif.stall) begin
        done = 1;
        break;
      end
      st++;
      if (!sram_oe_n) oe++;
      if (!sram_we_n) wl++;
      if (!sram_ce_n && sram_we_n && sram_data_oe) hold++;
      if (!sram_ce_n && sram_addr !== a[21:2]) addr_bad = 1;
      if (!sram_we_n && (sram_be_n !== be || sram_wdata !== wd)) be_bad = 1;
      if (!sram_oe_n && sram_be_n !== 4'h0) be_bad = 1;
      step();
    end
    chk("timeout", 32'(done), 32'd1);
    if (we) begin
      w = ref_mem[a[9:2]];
      for (int b = 0; b < 4; b++)
        if (!be[b]) w[8*b +: 8] = wd[8*b +: 8];
      ref_mem[a[9:2]] = w;
      chk("wr_stall_cycles", st, WR_WAIT + 2);
      chk("wr_oe_low", oe, 0);
      chk("wr_we_low", wl, WR_WAIT);
      chk("wr_hold", hold, 1);
    end else begin
      last_rd = ref_mem[a[9:2]];
      chk("rd_stall_cycles", st, RD_WAIT + 1);
      chk("rd_oe_low", oe, RD_WAIT);
      chk("rd_we_low", wl, 0);
    end
    chk("addr", 32'(addr_bad), 0);
    chk("be_data", 32'(be_bad), 0);
    chk("done_rdata", dmif.rdata, last_rd);
    chk("done_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    step();
    dmif.re = 0;
    dmif.we = 0;
    #1;
    chk("idle_stall", 32'(dmif.stall), 0);
    chk("idle_rdata", dmif.rdata, last_rd);
  endtask

  initial begin
    int mism;
    logic [31:0] a, wd;
    logic [3:0]  be;
    int kind;
    for (int i = 0; i < 256; i++) begin
      smem[i]    = $urandom;
      ref_mem[i] = smem[i];
    end
    rst_n = 0;
    dmif.re = 0; dmif.we = 0; dmif.addr = 0;
    dmif.be_n = 4'hF; dmif.wdata = 0;
    last_rd = 0;
    step();
    step();
    rst_n = 1;
    chk("rst_rdata", dmif.rdata, 0);
    chk("rst_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("rst_be", sram_be_n, 4'hF);
    chk("rst_stall", 32'(dmif.stall), 0);
    chk("rst_doe", 32'(sram_data_oe), 0);
    step();
    chk("idle_addr", 32'(sram_addr), 0);
    chk("idle_wdata", sram_wdata, 0);

    smem[8'h8D] = 32'hA5A5_5A5A;
    ref_mem[8'h8D] = 32'hA5A5_5A5A;
    access(1, 0, 32'h0000_1234, 4'hF, 0);
    access(0, 1, 32'h0000_0010, 4'b1101, 32'h0000_7700);
    access(1, 1, 32'h0000_0014, 4'h0, 32'h1122_3344);
    access(0, 1, 32'h0000_0020, 4'hF, 32'hFFFF_FFFF);
    access(0, 1, 32'h0000_0024, 4'h0, 32'hCAFE_F00D);
    access(1, 0, 32'h0000_0024, 4'hF, 0);
    access(1, 0, 32'h0000_0010, 4'hF, 0);
    access(1, 0, 32'h0000_0020, 4'hF, 0);

    for (int n = 0; n < 80; n++) begin
      kind = $urandom_range(0, 3);
      a    = $urandom;
      wd   = $urandom;
      be   = ($urandom_range(0, 5) == 0) ? 4'hF : 4'($urandom);
      access(kind != 1, kind != 0, a, be, wd);
      if ($urandom_range(0, 2) == 0)
        repeat ($urandom_range(1, 3)) step();
    end

    dmif.re = 1; dmif.addr = 32'h0000_0024;
    #1;
    step();
    step();
    chk("rst_mid_oe", 32'(sram_oe_n), 0);
    rst_n = 0;
    dmif.re = 0;
    step();
    rst_n = 1;
    chk("abort_strobes", {sram_ce_n, sram_oe_n, sram_we_n}, 3'b111);
    chk("abort_rdata", dmif.rdata, 0);
    chk("abort_stall", 32'(dmif.stall), 0);
    chk("abort_be", sram_be_n, 4'hF);
    last_rd = 0;
    step();
    access(1, 0, 32'h0000_0010, 4'hF, 0);

    mism = 0;
    for (int i = 0; i < 256; i++)
      if (smem[i] !== ref_mem[i]) mism++;
    chk("mem_image", mism, 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
